// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Hi/Lo special-purpose register block. Holds the Hi, Lo and status
//   registers and fills them from a sequential radix-2 shift-add multiplier
//   and an optional restoring divider. One operation runs at a time under a
//   start/busy/done handshake.
//
//   Build option: define HILO_DIV_EN to build the divider. Without it, DIVU
//   and DIVS finish in one cycle with only the ILL status bit set, and Hi and
//   Lo are left unchanged.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous reset, active-high
//   start    in   launch op (sampled only while not busy)
//   op       in   [1:0] 00 MULU, 01 MULS, 10 DIVU, 11 DIVS
//   a, b     in   [WIDTH-1:0] operands, captured when start is taken
//   wr_hi    in   move-to-Hi (ignored while busy)
//   wr_lo    in   move-to-Lo (ignored while busy)
//   wr_data  in   [WIDTH-1:0] move-to data
//   busy     out  high in RUN and DONE
//   done     out  one-cycle pulse, hi/lo/sr valid in that cycle
//   hi, lo   out  [WIDTH-1:0] Hi and Lo registers
//   sr       out  [SR_W-1:0] {.., ILL, OV, DZ, N, Z}
module hilo_muldiv_unit #(
  parameter int WIDTH = 16,
  parameter int SR_W  = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [SR_W-1:0]  sr
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic               a_neg_q, b_neg_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH:0]   acc;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [4:0]         flags_q;

  logic               fast, finish, res_wr;
  logic [2*WIDTH:0]   step;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   mul_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [4:0]         res_flags;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v,
                                           input logic sgn);
    if (sgn && (v < 0)) return -v;
    return v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_if(input logic [2*WIDTH-1:0] v,
                                                input logic n);
    return n ? -v : v;
  endfunction

  assign finish = (cnt == CW'(WIDTH));

  // Multiplier: accumulator upper half gains the multiplicand when the
  // multiplier LSB (acc[0]) is set, then the whole register shifts right.
  assign mul_sum  = acc[2*WIDTH:WIDTH] + {1'b0, opnd_q};
  assign mul_next = acc[0] ? {1'b0, mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH:1]};
  assign prod     = neg_if(acc[2*WIDTH-1:0], a_neg_q ^ b_neg_q);

`ifdef HILO_DIV_EN
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] a_q, b_q;
  logic             div_zero, div_ovf, div_ge;
  logic [2*WIDTH:0] div_shl, div_next;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] quo, rem;

  assign div_zero = op_q[1] && (b_q == '0);
  assign div_ovf  = (op_q == 2'b11) && (a_q == MIN_VAL) && (b_q == '1);
  assign fast     = div_zero || div_ovf;

  // Restoring step: upper field is the partial remainder, lower field shifts
  // dividend bits out and quotient bits in.
  assign div_shl  = {acc[2*WIDTH-1:0], 1'b0};
  assign div_ge   = div_shl[2*WIDTH:WIDTH] >= {1'b0, opnd_q};
  assign div_diff = div_shl[2*WIDTH:WIDTH] - {1'b0, opnd_q};
  assign div_next = div_ge ? {div_diff, div_shl[WIDTH-1:1], 1'b1} : div_shl;
  assign step     = op_q[1] ? div_next : mul_next;

  assign quo = neg_if({{WIDTH{1'b0}}, acc[WIDTH-1:0]}, a_neg_q ^ b_neg_q)[WIDTH-1:0];
  assign rem = neg_if({{WIDTH{1'b0}}, acc[2*WIDTH-1:WIDTH]}, a_neg_q)[WIDTH-1:0];
`else
  assign fast = op_q[1];
  assign step = mul_next;
`endif

  always_comb begin
    res_hi    = hi_q;
    res_lo    = lo_q;
    res_flags = 5'b0;
    if (op_q[1]) begin
`ifdef HILO_DIV_EN
      if (div_zero) begin
        res_hi = a_q;
        res_lo = '1;
      end else if (div_ovf) begin
        res_hi = '0;
        res_lo = MIN_VAL;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
      res_flags = {1'b0, div_ovf && !div_zero, div_zero,
                   res_hi[WIDTH-1], ({res_hi, res_lo} == '0)};
`else
      res_flags = 5'b10000;
`endif
    end else begin
      res_hi    = prod[2*WIDTH-1:WIDTH];
      res_lo    = prod[WIDTH-1:0];
      res_flags = {3'b000, res_hi[WIDTH-1], ({res_hi, res_lo} == '0)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    res_wr    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        // Fast-path ops are decided from latched operands on the first RUN cycle.
        if (fast || finish) begin
          res_wr    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q    <= '0;
      lo_q    <= '0;
      flags_q <= '0;
      cnt     <= '0;
    end else begin
      if (state == S_IDLE) begin
        if (wr_hi) hi_q <= wr_data;
        if (wr_lo) lo_q <= wr_data;
        if (start) cnt <= '0;
      end
      if (state == S_RUN && !res_wr) cnt <= cnt + CW'(1);
      if (res_wr) begin
        hi_q    <= res_hi;
        lo_q    <= res_lo;
        flags_q <= res_flags;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      op_q    <= op;
      a_neg_q <= op[0] & a[WIDTH-1];
      b_neg_q <= op[0] & b[WIDTH-1];
`ifdef HILO_DIV_EN
      a_q     <= a;
      b_q     <= b;
`endif
      if (op[1]) begin
        acc    <= {{(WIDTH+1){1'b0}}, mag(a, op[0])};
        opnd_q <= mag(b, op[0]);
      end else begin
        acc    <= {{(WIDTH+1){1'b0}}, mag(b, op[0])};
        opnd_q <= mag(a, op[0]);
      end
    end else if (state == S_RUN && !res_wr) begin
      acc <= step;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
  assign sr = {{(SR_W-5){1'b0}}, flags_q};

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed testbench for hilo_muldiv_unit (WIDTH=16). Expectations follow the
// HILO_DIV_EN build setting of the compile.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, wr_hi, wr_lo, busy, done;
  logic [1:0]  op;
  logic [15:0] a, b, wr_data, hi, lo;
  logic [8:0]  sr;

  int n_checks = 0;
  int n_pass   = 0;

  hilo_muldiv_unit #(.WIDTH(16), .SR_W(9)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .sr(sr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Starts an op at a falling edge and waits for done. Returns latency in
  // cycles after the start edge (-1 on timeout) and the outputs seen in the
  // done cycle. Optionally disturbs the run with start/move-to while busy.
  task automatic run_op(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv,
                        input bit disturb, output int lat,
                        output logic [15:0] h, output logic [15:0] l, output logic [8:0] s);
    lat = -1;
    h = 'x; l = 'x; s = 'x;
    op = o; a = av; b = bv; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; end
      if (disturb && k == 4) begin
        check("busy_mid_run", busy, 1);
        start = 1'b1; op = 2'b10; a = 16'h0FFF; b = 16'h0003;
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 16'hABCD;
      end
      if (disturb && k == 5) begin start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; end
      if (done) begin
        lat = k - 1; h = hi; l = lo; s = sr;
        break;
      end
    end
    @(negedge clk);
    check("done_one_cycle", {busy, done}, 2'b00);
  endtask

  int          lat, dn;
  logic [15:0] rh, rl;
  logic [8:0]  rs;

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hilo", {hi, lo}, 32'h0);
    check("rst_sr", sr, 0);
    rst = 1'b0;

    // Move-to writes in IDLE
    wr_hi = 1'b1; wr_data = 16'h1234;
    @(negedge clk);
    wr_hi = 1'b0;
    check("wr_hi", {hi, lo}, 32'h1234_0000);
    check("wr_hi_sr", sr, 0);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 16'h5A5A;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("wr_both", {hi, lo}, 32'h5A5A_5A5A);

    // MULU max * max
    run_op(2'b00, 16'hFFFF, 16'hFFFF, 0, lat, rh, rl, rs);
    check("mulu_lat", lat, 17);
    check("mulu_ff", {rh, rl}, 32'hFFFE_0001);
    check("mulu_ff_sr", rs, 9'h002);

    run_op(2'b01, 16'hFFFD, 16'h0007, 0, lat, rh, rl, rs);
    check("muls_neg", {rh, rl}, 32'hFFFF_FFEB);
    check("muls_neg_sr", rs, 9'h002);
    run_op(2'b01, 16'hFFFB, 16'hFFFA, 0, lat, rh, rl, rs);
    check("muls_negneg", {rh, rl}, 32'h0000_001E);
    run_op(2'b00, 16'h0000, 16'h1234, 0, lat, rh, rl, rs);
    check("mulu_zero", {rh, rl}, 32'h0);
    check("mulu_zero_sr", rs, 9'h001);

    // Divides; a move-to accepted with start lands first
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 16'hBEEF;
    run_op(2'b11, 16'hFFF9, 16'h0002, 0, lat, rh, rl, rs);
`ifdef HILO_DIV_EN
    check("divs_lat", lat, 17);
    check("divs_m7_2", {rh, rl}, 32'hFFFF_FFFD);
    check("divs_m7_2_sr", rs, 9'h002);
`else
    check("ill_lat", lat, 1);
    check("ill_hilo", {rh, rl}, 32'hBEEF_BEEF);
    check("ill_sr", rs, 9'h010);
`endif
    run_op(2'b10, 16'h0064, 16'h0000, 0, lat, rh, rl, rs);
    check("divz_lat", lat, 1);
`ifdef HILO_DIV_EN
    check("divz", {rh, rl}, 32'h0064_FFFF);
    check("divz_sr", rs, 9'h004);
`else
    check("ill_divz", {rh, rl}, 32'hBEEF_BEEF);
    check("ill_divz_sr", rs, 9'h010);
`endif
    run_op(2'b11, 16'h8000, 16'hFFFF, 0, lat, rh, rl, rs);
    check("ovf_lat", lat, 1);
`ifdef HILO_DIV_EN
    check("divs_ovf", {rh, rl}, 32'h0000_8000);
    check("divs_ovf_sr", rs, 9'h008);
    run_op(2'b10, 16'h0064, 16'h0007, 0, lat, rh, rl, rs);
    check("divu_100_7", {rh, rl}, 32'h0002_000E);
    check("divu_100_7_sr", rs, 9'h000);
    run_op(2'b11, 16'h0007, 16'hFFFE, 0, lat, rh, rl, rs);
    check("divs_7_m2", {rh, rl}, 32'h0001_FFFD);
`else
    check("ill_ovf_sr", rs, 9'h010);
`endif

    // Move-to with accepted start is overwritten by the result
    wr_lo = 1'b1; wr_data = 16'h9999;
    run_op(2'b00, 16'h0002, 16'h0003, 0, lat, rh, rl, rs);
    check("mul_over_wr", {rh, rl}, 32'h0000_0006);
    check("mul_over_wr_sr", rs, 9'h000);

    // start and move-to during RUN are ignored
    run_op(2'b00, 16'h0100, 16'h0100, 1, lat, rh, rl, rs);
    check("disturb_lat", lat, 17);
    check("disturb_res", {rh, rl}, 32'h0001_0000);
    @(negedge clk);
    check("disturb_idle", {busy, hi, lo}, {1'b0, 32'h0001_0000});

    // Reset in the 5th RUN cycle aborts the op
    op = 2'b00; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_hilo", {hi, lo}, 32'h0);
    check("abort_sr", sr, 0);
    dn = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);
    check("abort_hilo_after", {hi, lo}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
